fetch_align: RTL and testbench

Instruction fetch and alignment stage that sits directly upstream of the executor. It fetches 32-bit aligned words over a single-outstanding memory port and extracts 16-bit (compressed) or 32-bit instructions at any halfword-aligned pc, including 32-bit instructions that straddle two words. It presents one instruction plus its pc per handshake, advances pc by 2 or 4 using the same rule the executor applies for pc_inc (instr[1:0]!=2'b11 means 16-bit), and accepts taken-branch/jump redirects.

---
 rtl/fetch_align_pkg.sv | 18 +
 rtl/fetch_align_if.sv | 24 ++
 rtl/fetch_align.sv | 147 ++++++++++++++
 tb/tb_fetch_align.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_align_pkg.sv
// Shared types and helpers for the instruction fetch/align stage.
package riscv_fetch_pkg;

  typedef enum logic [1:0] {
    S_FETCH,
    S_FETCH2,
    S_OUT,
    S_DROP
  } state_e;

  localparam logic [31:0] PC_INC_C = 32'd2;
  localparam logic [31:0] PC_INC_W = 32'd4;

  function automatic logic is_rvc(input logic [15:0] half);
    return half[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/fetch_align_if.sv
// Executor handshake, redirect and memory port of the fetch/align stage.
interface fetch_align_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_ready;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        instr_valid;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic        is_compressed;

  modport master (
    input  redirect_valid, redirect_pc, instr_ready, mem_rdata, mem_ready,
    output mem_req, mem_addr, instr_valid, instruction, pc, is_compressed
  );

  modport slave (
    output redirect_valid, redirect_pc, instr_ready, mem_rdata, mem_ready,
    input  mem_req, mem_addr, instr_valid, instruction, pc, is_compressed
  );
endinterface

// File: rtl/fetch_align.sv
// Fetch/align stage: single-outstanding word fetch, halfword-aligned
// extraction of 16/32-bit instructions including word-straddling ones.
module fetch_align
  import riscv_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  fetch_align_if.master bus
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] buf_word_q, buf_word_d;
  logic [29:0] buf_addr_q, buf_addr_d;
  logic        buf_v_q, buf_v_d;
  logic [15:0] hi_half_q, hi_half_d;
  logic [29:0] drop_addr_q, drop_addr_d;

  logic [15:0] first_half;
  logic        cur_rvc;
  logic [31:0] cur_instr;
  logic [31:0] next_pc;
  logic [29:0] fetch_addr;
  logic        req_state;
  logic        out_valid;

  // hi_half always holds the halfword at pc when pc[1]=1; in a straddle
  // buf_word then holds the following word whose low half completes it.
  always_comb begin
    first_half = pc_q[1] ? hi_half_q : buf_word_q[15:0];
    cur_rvc    = is_rvc(first_half);
    if (cur_rvc)
      cur_instr = {16'h0000, first_half};
    else if (pc_q[1])
      cur_instr = {buf_word_q[15:0], hi_half_q};
    else
      cur_instr = buf_word_q;
    next_pc = pc_q + (cur_rvc ? PC_INC_C : PC_INC_W);
  end

  always_comb begin
    fetch_addr = pc_q[31:2];
    case (state_q)
      S_FETCH2: fetch_addr = buf_addr_q + 30'd1;
      S_DROP:   fetch_addr = drop_addr_q;
      default:  fetch_addr = pc_q[31:2];
    endcase
    req_state = (state_q == S_FETCH) || (state_q == S_FETCH2) ||
                (state_q == S_DROP);
    out_valid = (state_q == S_OUT);
  end

  assign bus.mem_req       = req_state && !rst;
  assign bus.mem_addr      = {fetch_addr, 2'b00};
  assign bus.instr_valid   = out_valid;
  assign bus.instruction   = out_valid ? cur_instr : '0;
  assign bus.is_compressed = out_valid && cur_rvc;
  assign bus.pc            = pc_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    buf_word_d  = buf_word_q;
    buf_addr_d  = buf_addr_q;
    buf_v_d     = buf_v_q;
    hi_half_d   = hi_half_q;
    drop_addr_d = drop_addr_q;

    case (state_q)
      S_FETCH: begin
        if (bus.mem_ready) begin
          buf_word_d = bus.mem_rdata;
          buf_addr_d = pc_q[31:2];
          buf_v_d    = 1'b1;
          hi_half_d  = bus.mem_rdata[31:16];
          if (pc_q[1] && !is_rvc(bus.mem_rdata[31:16]))
            state_d = S_FETCH2;
          else
            state_d = S_OUT;
        end
      end
      S_FETCH2: begin
        if (bus.mem_ready) begin
          buf_word_d = bus.mem_rdata;
          buf_addr_d = buf_addr_q + 30'd1;
          state_d    = S_OUT;
        end
      end
      S_OUT: begin
        if (bus.instr_ready) begin
          pc_d      = next_pc;
          hi_half_d = buf_word_q[31:16];
          if (buf_v_q && (next_pc[31:2] == buf_addr_q)) begin
            if (!next_pc[1] || is_rvc(buf_word_q[31:16]))
              state_d = S_OUT;
            else
              state_d = S_FETCH2;
          end else begin
            state_d = S_FETCH;
          end
        end
      end
      S_DROP: begin
        if (bus.mem_ready)
          state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    // A request cannot be withdrawn: park its address in S_DROP until it completes.
    if (bus.redirect_valid) begin
      pc_d       = bus.redirect_pc & ~32'h1;
      buf_v_d    = 1'b0;
      buf_word_d = buf_word_q;
      buf_addr_d = buf_addr_q;
      if (req_state && !bus.mem_ready) begin
        state_d     = S_DROP;
        drop_addr_d = fetch_addr;
      end else begin
        state_d = S_FETCH;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_FETCH;
      pc_q        <= {RESET_PC[31:1], 1'b0};
      buf_word_q  <= '0;
      buf_addr_q  <= '0;
      buf_v_q     <= 1'b0;
      hi_half_q   <= '0;
      drop_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      buf_word_q  <= buf_word_d;
      buf_addr_q  <= buf_addr_d;
      buf_v_q     <= buf_v_d;
      hi_half_q   <= hi_half_d;
      drop_addr_q <= drop_addr_d;
    end
  end

endmodule

// File: tb/tb_fetch_align.sv
// Bench for fetch_align: directed timing scenarios, then random stalls,
// waits and redirects checked against an instruction-stream model.
module tb_fetch_align;

  logic clk;
  logic rst;
  logic ready_en;
  logic [31:0] mem [128];

  int n_cmp = 0;
  int n_err = 0;

  fetch_align_if bus();

  fetch_align #(.RESET_PC(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.mem_ready = bus.mem_req & ready_en;
  assign bus.mem_rdata = mem[bus.mem_addr[8:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ready_en = 1'b1;
    bus.instr_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    tick();
    tick();
  endtask

  task automatic release_rst();
    rst = 1'b0;
    #1;
  endtask

  function automatic logic [15:0] half_at(input logic [31:0] a);
    logic [31:0] w;
    w = mem[a[8:2]];
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  // Instruction located at address a, per the 16/32-bit length rule.
  function automatic logic [31:0] exp_instr(input logic [31:0] a);
    logic [15:0] h0;
    h0 = half_at(a);
    if (h0[1:0] != 2'b11) return {16'h0000, h0};
    return {half_at(a + 32'd2), h0};
  endfunction

  initial begin
    logic [31:0] model_pc;
    logic [31:0] e;
    logic [31:0] rpc;
    logic [31:0] prev_addr;
    logic prev_pend;
    logic exp_inv;
    logic redir;
    int idle;

    for (int unsigned i = 0; i < 128; i++) mem[i] = '0;

    // aligned 32-bit instruction, zero-wait
    mem[0] = 32'h0050_0093;
    do_reset();
    chk("rst_valid", bus.instr_valid, 0);
    chk("rst_instr", bus.instruction, 0);
    chk("rst_comp", bus.is_compressed, 0);
    chk("rst_pc", bus.pc, 0);
    chk("rst_req", bus.mem_req, 0);
    release_rst();
    chk("t1_req", bus.mem_req, 1);
    chk("t1_addr", bus.mem_addr, 0);
    bus.instr_ready = 1'b1;
    tick();
    chk("t1_valid", bus.instr_valid, 1);
    chk("t1_instr", bus.instruction, 32'h0050_0093);
    chk("t1_pc", bus.pc, 0);
    chk("t1_comp", bus.is_compressed, 0);
    tick();
    chk("t1_next_addr", bus.mem_addr, 4);
    chk("t1_next_req", bus.mem_req, 1);

    // two compressed in one word
    mem[0] = 32'h4501_4505;
    do_reset();
    release_rst();
    bus.instr_ready = 1'b1;
    tick();
    chk("t2_pc0", bus.pc, 0);
    chk("t2_i0", bus.instruction, 32'h0000_4505);
    chk("t2_comp0", bus.is_compressed, 1);
    chk("t2_req0", bus.mem_req, 0);
    tick();
    chk("t2_pc2", bus.pc, 2);
    chk("t2_i2", bus.instruction, 32'h0000_4501);
    chk("t2_req2", bus.mem_req, 0);
    tick();
    chk("t2_addr", bus.mem_addr, 4);

    // straddle
    mem[0] = 32'h0093_4505;
    mem[1] = 32'h0000_0050;
    do_reset();
    release_rst();
    bus.instr_ready = 1'b1;
    tick();
    chk("t3_i0", bus.instruction, 32'h0000_4505);
    tick();
    chk("t3_f2_req", bus.mem_req, 1);
    chk("t3_f2_addr", bus.mem_addr, 4);
    chk("t3_f2_valid", bus.instr_valid, 0);
    tick();
    chk("t3_pc2", bus.pc, 2);
    chk("t3_i2", bus.instruction, 32'h0050_0093);
    tick();
    chk("t3_pc6", bus.pc, 6);
    chk("t3_v6", bus.instr_valid, 1);

    // memory wait states
    mem[0] = 32'h0050_0093;
    do_reset();
    ready_en = 1'b0;
    release_rst();
    for (int unsigned i = 0; i < 3; i++) begin
      chk("t4_req", bus.mem_req, 1);
      chk("t4_addr", bus.mem_addr, 0);
      chk("t4_valid", bus.instr_valid, 0);
      tick();
    end
    ready_en = 1'b1;
    tick();
    chk("t4_valid_after", bus.instr_valid, 1);

    // redirect during a pending fetch, then stall, then reset mid-stall
    mem[1]  = 32'hdead_beef;
    mem[64] = 32'h4585_0000;
    do_reset();
    release_rst();
    bus.instr_ready = 1'b1;
    tick();
    ready_en = 1'b0;
    tick();
    chk("t5_addr4", bus.mem_addr, 4);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h103;
    tick();
    bus.redirect_valid = 1'b0;
    chk("t5_drop_addr", bus.mem_addr, 4);
    chk("t5_drop_req", bus.mem_req, 1);
    chk("t5_drop_valid", bus.instr_valid, 0);
    tick();
    chk("t5_drop_addr2", bus.mem_addr, 4);
    ready_en = 1'b1;
    tick();
    chk("t5_new_addr", bus.mem_addr, 32'h100);
    bus.instr_ready = 1'b0;
    tick();
    chk("t5_valid", bus.instr_valid, 1);
    chk("t5_pc", bus.pc, 32'h102);
    chk("t5_instr", bus.instruction, 32'h0000_4585);
    for (int unsigned i = 0; i < 5; i++) begin
      tick();
      chk("t6_stall_pc", bus.pc, 32'h102);
      chk("t6_stall_instr", bus.instruction, 32'h0000_4585);
      chk("t6_stall_req", bus.mem_req, 0);
    end
    rst = 1'b1;
    tick();
    chk("t6_rst_valid", bus.instr_valid, 0);
    chk("t6_rst_pc", bus.pc, 0);

    // random phase
    for (int unsigned i = 0; i < 128; i++) mem[i] = $urandom;
    do_reset();
    release_rst();
    model_pc = 32'h0;
    prev_pend = 1'b0;
    prev_addr = '0;
    exp_inv = 1'b0;
    idle = 0;
    for (int c = 0; c < 4000; c++) begin
      if (prev_pend) begin
        chk("req_hold", bus.mem_req, 1);
        chk("addr_hold", bus.mem_addr, prev_addr);
      end
      if (exp_inv) chk("redir_inval", bus.instr_valid, 0);
      idle = bus.instr_valid ? 0 : idle + 1;
      if (idle > 40) begin
        chk("watchdog_idle", idle, 0);
        break;
      end
      ready_en = ($urandom_range(0, 2) != 0);
      bus.instr_ready = ($urandom_range(0, 3) != 0);
      redir = ($urandom_range(0, 31) == 0);
      rpc = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 511))
                                        : 32'hFFFF_FFC0 + 32'($urandom_range(0, 63));
      bus.redirect_valid = redir;
      bus.redirect_pc = rpc;
      #1;
      prev_pend = bus.mem_req && !bus.mem_ready;
      prev_addr = bus.mem_addr;
      if (bus.instr_valid && bus.instr_ready) begin
        e = exp_instr(model_pc);
        chk("rnd_pc", bus.pc, model_pc);
        chk("rnd_instr", bus.instruction, e);
        chk("rnd_comp", bus.is_compressed, {31'h0, e[1:0] != 2'b11});
        model_pc = model_pc + ((e[1:0] != 2'b11) ? 32'd2 : 32'd4);
      end
      if (redir) model_pc = rpc & ~32'h1;
      exp_inv = redir;
      tick();
    end
    bus.redirect_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
